// File: rtl/ex_fp32.sv
// FP32 integer-power unit: S = in ** sel (sel unsigned, 0..31).
// Iterative: one FP32 multiply per busy cycle into an accumulator seeded with 1.0.
module ex_fp32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] in,
    input  logic [4:0]  sel,
    output logic [31:0] S,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_n;
    logic [31:0] acc;
    logic [31:0] x;
    logic [4:0]  cnt;
    logic [31:0] prod;

    // Flush-to-zero FP32 multiply, round-to-nearest-even, canonical quiet NaN.
    function automatic logic [31:0] fpmul(input logic [31:0] a, input logic [31:0] b);
        logic               s;
        logic [7:0]         ea, eb;
        logic [22:0]        fa, fb;
        logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic [47:0]        p;
        logic [22:0]        frac;
        logic               g, st;
        logic [24:0]        m;
        logic [22:0]        frac_out;
        logic signed [10:0] e;
        logic [31:0]        r;
        begin
            s      = a[31] ^ b[31];
            ea     = a[30:23];
            eb     = b[30:23];
            fa     = a[22:0];
            fb     = b[22:0];
            a_zero = (ea == 8'h00);
            b_zero = (eb == 8'h00);
            a_inf  = (ea == 8'hFF) && (fa == '0);
            b_inf  = (eb == 8'hFF) && (fb == '0);
            a_nan  = (ea == 8'hFF) && (fa != '0);
            b_nan  = (eb == 8'hFF) && (fb != '0);

            p = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
            if (p[47]) begin
                frac = p[46:24];
                g    = p[23];
                st   = |p[22:0];
            end else begin
                frac = p[45:23];
                g    = p[22];
                st   = |p[21:0];
            end
            m = {2'b01, frac} + {24'd0, g & (st | frac[0])};
            // A rounding carry out of the mantissa leaves exactly 2^24, so shift and bump the exponent.
            frac_out = m[24] ? m[23:1] : m[22:0];
            e = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127
                + $signed({10'd0, p[47]}) + $signed({10'd0, m[24]});

            if (a_nan || b_nan)
                r = 32'h7FC00000;
            else if (a_inf || b_inf)
                r = (a_zero || b_zero) ? 32'h7FC00000 : {s, 8'hFF, 23'd0};
            else if (a_zero || b_zero)
                r = {s, 31'd0};
            else if (e >= 11'sd255)
                r = {s, 8'hFF, 23'd0};
            else if (e <= 11'sd0)
                r = {s, 31'd0};
            else
                r = {s, e[7:0], frac_out};
            return r;
        end
    endfunction

    assign prod = fpmul(acc, x);
    assign busy = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) state_n = RUN;
            RUN:  if (cnt == '0) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S    <= '0;
            done <= 1'b0;
            acc  <= '0;
            x    <= '0;
            cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    x   <= in;
                    cnt <= sel;
                    acc <= 32'h3F800000;
                end
            end else if (cnt != '0) begin
                acc <= prod;
                cnt <= cnt - 5'd1;
            end else begin
                S    <= acc;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex_fp32.sv
// Scoreboard bench for ex_fp32: directed power vectors plus random bases
// checked against a real-arithmetic rounding model.
module tb_ex_fp32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] in = '0;
    logic [4:0]  sel = '0;
    logic [31:0] S;
    logic        busy;
    logic        done;

    ex_fp32 dut (
        .clk(clk), .rst(rst), .start(start), .in(in), .sel(sel),
        .S(S), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] s;
        int          c;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: pops one expectation per done pulse and checks value and latency.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 S=%h expected no pending op", S);
            end else begin
                mon_e = q.pop_front();
                check({mon_e.name, "_S"}, S, mon_e.s);
                check({mon_e.name, "_lat"}, 32'(cyc), 32'(mon_e.c));
            end
        end
    end

    function automatic real to_real(input logic [31:0] b);
        real v;
        int  ex;
        v  = real'({1'b1, b[22:0]});
        ex = int'(b[30:23]) - 150;
        while (ex > 0) begin v = v * 2.0; ex--; end
        while (ex < 0) begin v = v / 2.0; ex++; end
        return v;
    endfunction

    // Exact double product, then rounded to a 24-bit significand with ties to even.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic   s;
        real    m, fl, fr;
        int     k, be;
        longint li;
        s = a[31] ^ b[31];
        if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
            return 32'h7FC00000;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
            return (a[30:23] == 8'h00 || b[30:23] == 8'h00) ? 32'h7FC00000 : {s, 8'hFF, 23'd0};
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00)
            return {s, 31'd0};
        m = to_real(a) * to_real(b);
        k = 0;
        while (m >= 16777216.0) begin m = m / 2.0; k++; end
        while (m < 8388608.0) begin m = m * 2.0; k--; end
        fl = $floor(m);
        fr = m - fl;
        li = longint'(fl);
        if (fr > 0.5 || (fr == 0.5 && li[0])) li++;
        if (li == 64'd16777216) begin li = 64'd8388608; k++; end
        be = k + 150;
        if (be >= 255) return {s, 8'hFF, 23'd0};
        if (be <= 0) return {s, 31'd0};
        return {s, be[7:0], li[22:0]};
    endfunction

    task automatic drain(input string name);
        int guard = 0;
        while (q.size() != 0 && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no done within 60 cycles, expected done", name);
            q.delete();
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] base, input logic [4:0] s,
                          input logic [31:0] expv);
        int guard = 0;
        while (busy && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        in    = base;
        sel   = s;
        start = 1'b1;
        q.push_back('{expv, cyc + 2 + int'(s), name});
        @(posedge clk); #1;
        start = 1'b0;
        check({name, "_busy"}, {31'd0, busy}, 32'd1);
        drain(name);
    endtask

    initial begin
        logic [31:0] rb;
        logic [4:0]  rs;
        logic [31:0] racc;

        @(posedge clk); #1;
        check("rst_S", S, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("two_pow10", 32'h40000000, 5'd10, 32'h44800000);
        run_op("neg2_pow3", 32'hC0000000, 5'd3, 32'hC1000000);
        run_op("1p5_pow2", 32'h3FC00000, 5'd2, 32'h40100000);
        run_op("three_pow3", 32'h40400000, 5'd3, 32'h41D80000);
        run_op("zero_pow29", 32'h00000000, 5'd29, 32'h00000000);
        run_op("nan_pow0", 32'h7FC00000, 5'd0, 32'h3F800000);
        run_op("zero_pow0", 32'h00000000, 5'd0, 32'h3F800000);
        run_op("neginf_pow26", 32'hFF800000, 5'd26, 32'h7F800000);
        run_op("neginf_pow3", 32'hFF800000, 5'd3, 32'hFF800000);
        run_op("ovf_pow5", 32'h4F800000, 5'd5, 32'h7F800000);
        run_op("nan_pow31", 32'h7F800001, 5'd31, 32'h7FC00000);
        run_op("sticky_sq", 32'h3F800001, 5'd2, 32'h3F800002);
        run_op("tie_even_sq", 32'h3F800800, 5'd2, 32'h3F801000);
        run_op("subnorm_pow1", 32'h80000123, 5'd1, 32'h80000000);
        run_op("tiny_pow2", 32'h1F800000, 5'd2, 32'h00000000);

        // start while busy must be ignored, as must in/sel changes
        in    = 32'h40000000;
        sel   = 5'd3;
        start = 1'b1;
        q.push_back('{32'h41000000, cyc + 5, "busy_ignore"});
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        in    = 32'h40400000;
        sel   = 5'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drain("busy_ignore");
        repeat (10) @(posedge clk);
        #1;

        // asynchronous reset mid-operation; S holds 8.0 beforehand
        in    = 32'h40000000;
        sel   = 5'd20;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_S", S, 32'h0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        start = 1'b1;
        @(posedge clk); #1;
        check("rst_vs_start_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk); #1;
        run_op("post_rst", 32'h40000000, 5'd4, 32'h41800000);

        for (int i = 0; i < 12; i++) begin
            rb   = {1'($urandom_range(0, 1)), 8'($urandom_range(122, 132)), 23'($urandom)};
            rs   = 5'($urandom_range(0, 31));
            racc = 32'h3F800000;
            for (int j = 0; j < int'(rs); j++) racc = ref_mul(racc, rb);
            run_op($sformatf("rand%0d_%h_%0d", i, rb, rs), rb, rs, racc);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
